// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared types and constants for the SPI monarch (spi_mnrch).
//   - spi_state_t   : transaction FSM states
//   - SCLK_DIV_INIT : divider value held while idle (SCLK high, 5 clks of
//                     front porch before the first fall)
//   - SMPL_PT       : divider value one clk before SCLK rises (sample MISO)
//   - SHFT_PT       : divider value one clk before SCLK falls (shift)
//   - NUM_BITS      : transaction length
// ---------------------------------------------------------------------------
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRONT = 2'd1,
    SHIFT = 2'd2,
    BACK  = 2'd3
  } spi_state_t;

  localparam logic [3:0] SCLK_DIV_INIT = 4'b1011;
  localparam logic [3:0] SMPL_PT       = 4'b0111;
  localparam logic [3:0] SHFT_PT       = 4'b1111;
  localparam int         NUM_BITS      = 16;

  // Bit counter value at the final sample of a transaction.
  localparam logic [3:0] BIT_LAST      = 4'(NUM_BITS - 1);

endpackage : spi_pkg

// File: rtl/spi_mnrch.sv
// ---------------------------------------------------------------------------
// spi_mnrch
// SPI monarch issuing one 16-bit full-duplex mode-3 transaction (CPOL=1,
// CPHA=1) per accepted wrt strobe. SCLK runs at clk/16.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   wrt      in   one-cycle start strobe, ignored unless idle
//   wt_data  in   [15:0] word to send, MSB first, captured on wrt
//   rd_data  out  [15:0] received word (shift register contents)
//   done     out  set at transaction end, held until next accepted wrt
//   SS_n     out  active-low serf select
//   SCLK     out  serial clock, idles high
//   MOSI     out  serial data out (shift register bit 15)
//   MISO     in   serial data in
// ---------------------------------------------------------------------------
module spi_mnrch
  import spi_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wrt,
  input  logic [15:0] wt_data,
  output logic [15:0] rd_data,
  output logic        done,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  spi_state_t  state_r;
  spi_state_t  state_s;
  logic [3:0]  sclk_div_r;
  logic [3:0]  bit_cnt_r;
  logic [15:0] shft_reg_r;
  logic        miso_smpl_r;
  logic        ss_n_r;
  logic        done_r;

  logic        ld_s;    // accept a new word
  logic        smpl_s;  // capture MISO ahead of the SCLK rise
  logic        shft_s;  // shift ahead of the SCLK fall
  logic        fin_s;   // last shift; close the transaction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and datapath strobes.
  always_comb begin
    state_s = state_r;
    ld_s    = 1'b0;
    smpl_s  = 1'b0;
    shft_s  = 1'b0;
    fin_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (wrt) begin
          ld_s    = 1'b1;
          state_s = FRONT;
        end else begin
          state_s = IDLE;
        end
      end
      FRONT: begin
        // The first SCLK fall carries no shift: MOSI already shows bit 15.
        if (sclk_div_r == SHFT_PT) begin
          state_s = SHIFT;
        end else begin
          state_s = FRONT;
        end
      end
      SHIFT: begin
        if (sclk_div_r == SMPL_PT) begin
          smpl_s = 1'b1;
          if (bit_cnt_r == BIT_LAST) begin
            state_s = BACK;
          end else begin
            state_s = SHIFT;
          end
        end else if (sclk_div_r == SHFT_PT) begin
          shft_s = 1'b1;
        end else begin
          state_s = SHIFT;
        end
      end
      BACK: begin
        // The 16th shift happens here, but the divider is reloaded on the
        // same clk so SCLK does not fall a 17th time.
        if (sclk_div_r == SHFT_PT) begin
          shft_s  = 1'b1;
          fin_s   = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = BACK;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // SCLK divider: parked while idle, free-running during a transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_div_r <= SCLK_DIV_INIT;
    end else if (ld_s || fin_s || (state_r == IDLE)) begin
      sclk_div_r <= SCLK_DIV_INIT;
    end else begin
      sclk_div_r <= sclk_div_r + 4'd1;
    end
  end

  // Bit counter: number of shifts performed in this transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_r <= 4'd0;
    end else if (ld_s) begin
      bit_cnt_r <= 4'd0;
    end else if (shft_s) begin
      bit_cnt_r <= bit_cnt_r + 4'd1;
    end else begin
      bit_cnt_r <= bit_cnt_r;
    end
  end

  // MISO sample flop, loaded one clk before each SCLK rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_smpl_r <= 1'b0;
    end else if (smpl_s) begin
      miso_smpl_r <= MISO;
    end else begin
      miso_smpl_r <= miso_smpl_r;
    end
  end

  // Full-duplex shift register: MSB out on MOSI, sampled MISO in at LSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shft_reg_r <= 16'h0000;
    end else if (ld_s) begin
      shft_reg_r <= wt_data;
    end else if (shft_s) begin
      shft_reg_r <= {shft_reg_r[14:0], miso_smpl_r};
    end else begin
      shft_reg_r <= shft_reg_r;
    end
  end

  // Serf select and completion flag, both registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ss_n_r <= 1'b1;
      done_r <= 1'b0;
    end else if (ld_s) begin
      ss_n_r <= 1'b0;
      done_r <= 1'b0;
    end else if (fin_s) begin
      ss_n_r <= 1'b1;
      done_r <= 1'b1;
    end else begin
      ss_n_r <= ss_n_r;
      done_r <= done_r;
    end
  end

  assign SCLK    = sclk_div_r[3];
  assign MOSI    = shft_reg_r[15];
  assign rd_data = shft_reg_r;
  assign SS_n    = ss_n_r;
  assign done    = done_r;

endmodule : spi_mnrch

// File: tb/tb_spi_mnrch.sv
// ---------------------------------------------------------------------------
// tb_spi_mnrch
// Directed bench for spi_mnrch with a small iNEMO-like mode-3 serf model
// (WHO_AM_I at 0x0F reads 0x6A; writing 0x02 to 0x0D sets up INT) and an
// optional MISO-to-MOSI loopback.
// ---------------------------------------------------------------------------
module tb_spi_mnrch;

  logic        clk;
  logic        rst_n;
  logic        wrt;
  logic [15:0] wt_data;
  logic [15:0] rd_data;
  logic        done;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;

  int n_checks;
  int n_fail;

  spi_mnrch dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wrt     (wrt),
    .wt_data (wt_data),
    .rd_data (rd_data),
    .done    (done),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (MISO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- serf model ----------------
  logic [7:0]  serf_regs [0:127];
  logic [15:0] serf_rx;
  logic [7:0]  serf_tx;
  int          serf_cnt;
  logic        serf_miso;
  logic        serf_setup;
  logic        INT;
  logic        loop_en;

  assign MISO = loop_en ? MOSI : serf_miso;

  initial begin
    for (int i = 0; i < 128; i++) serf_regs[i] = 8'h00;
    serf_regs[7'h0F] = 8'h6A;
    serf_setup = 1'b0;
    INT        = 1'b0;
    serf_miso  = 1'b0;
    serf_cnt   = 0;
    serf_rx    = 16'h0000;
    serf_tx    = 8'h00;
  end

  always @(negedge SS_n) begin
    serf_cnt  = 0;
    serf_rx   = 16'h0000;
    serf_tx   = 8'h00;
    serf_miso = 1'b0;
  end

  always @(posedge SCLK) begin
    if (!SS_n) begin
      serf_rx  = {serf_rx[14:0], MOSI};
      serf_cnt = serf_cnt + 1;
      if (serf_cnt == 8 && serf_rx[7]) serf_tx = serf_regs[serf_rx[6:0]];
      if (serf_cnt == 16 && !serf_rx[15]) begin
        serf_regs[serf_rx[14:8]] = serf_rx[7:0];
        if (serf_rx[14:8] == 7'h0D && serf_rx[7:0] == 8'h02) begin
          serf_setup = 1'b1;
          INT        = 1'b1;
        end
      end
    end
  end

  always @(negedge SCLK) begin
    if (!SS_n) begin
      if (serf_cnt >= 8) begin
        serf_miso = serf_tx[7];
        serf_tx   = {serf_tx[6:0], 1'b0};
      end else begin
        serf_miso = 1'b0;
      end
    end
  end

  // ---------------- edge monitors ----------------
  logic        mon_en;
  int          n_rise;
  int          n_fall;
  int          n_done;
  logic [15:0] mosi_seq;

  initial begin
    mon_en   = 1'b0;
    n_rise   = 0;
    n_fall   = 0;
    n_done   = 0;
    mosi_seq = 16'h0000;
  end

  always @(posedge SCLK) if (mon_en) begin
    n_rise   = n_rise + 1;
    mosi_seq = {mosi_seq[14:0], MOSI};
  end
  always @(negedge SCLK) if (mon_en) n_fall = n_fall + 1;
  always @(posedge done) n_done = n_done + 1;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  // Pulse wrt for one clk with the given word.
  task automatic pulse_wrt(input logic [15:0] data);
    @(negedge clk);
    wt_data = data;
    wrt     = 1'b1;
    @(posedge clk);
    #1;
    wrt     = 1'b0;
  endtask

  // Wait for done with a bounded budget; counts a timeout as a failure.
  task automatic wait_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_done_in_time"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic read_who_am_i(input string tag);
    pulse_wrt(16'h8F00);
    check({tag, "_ss_low"}, {31'd0, SS_n}, 32'd0);
    wait_done(tag);
    check({tag, "_rd_byte"}, {24'd0, rd_data[7:0]}, 32'h6A);
    check({tag, "_ss_high"}, {31'd0, SS_n}, 32'd1);
    check({tag, "_sclk_high"}, {31'd0, SCLK}, 32'd1);
  endtask

  int sclk_changes;
  logic sclk_prev;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    wrt      = 1'b0;
    wt_data  = 16'h0000;
    loop_en  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ss_n", {31'd0, SS_n}, 32'd1);
    check("rst_sclk", {31'd0, SCLK}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_mosi", {31'd0, MOSI}, 32'd0);
    check("rst_rd_data", {16'd0, rd_data}, 32'd0);

    // SCLK stays parked while idle
    sclk_changes = 0;
    sclk_prev    = SCLK;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (SCLK !== sclk_prev) sclk_changes++;
      sclk_prev = SCLK;
    end
    check("idle_sclk_changes", sclk_changes, 32'd0);

    // WHO_AM_I read
    read_who_am_i("who");

    // Register write 0x0D <= 0x02
    pulse_wrt(16'h0D02);
    check("wr_ss_low", {31'd0, SS_n}, 32'd0);
    wait_done("wr");
    check("wr_reg0d", {24'd0, serf_regs[7'h0D]}, 32'h02);
    check("wr_setup", {31'd0, serf_setup}, 32'd1);
    check("wr_int", {31'd0, INT}, 32'd1);

    // Bit timing with loopback
    repeat (4) @(posedge clk);
    loop_en  = 1'b1;
    n_rise   = 0;
    n_fall   = 0;
    mosi_seq = 16'h0000;
    mon_en   = 1'b1;
    pulse_wrt(16'hA55A);
    wait_done("bt");
    repeat (20) @(posedge clk);
    mon_en = 1'b0;
    check("bt_falls", n_fall, 32'd16);
    check("bt_rises", n_rise, 32'd16);
    check("bt_mosi_seq", {16'd0, mosi_seq}, 32'hA55A);
    check("bt_rd_data", {16'd0, rd_data}, 32'hA55A);

    // wrt during SHIFT is ignored
    n_done = 0;
    pulse_wrt(16'h1234);
    repeat (100) @(posedge clk);
    pulse_wrt(16'hFFFF);
    wait_done("mid");
    repeat (300) @(posedge clk);
    #1;
    check("mid_rd_data", {16'd0, rd_data}, 32'h1234);
    check("mid_done_count", n_done, 32'd1);
    check("mid_ss_idle", {31'd0, SS_n}, 32'd1);
    loop_en = 1'b0;

    // Reset during SHIFT
    pulse_wrt(16'h8F00);
    repeat (100) @(posedge clk);
    check("rmid_ss_active", {31'd0, SS_n}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rmid_ss_n", {31'd0, SS_n}, 32'd1);
    check("rmid_sclk", {31'd0, SCLK}, 32'd1);
    check("rmid_done", {31'd0, done}, 32'd0);
    check("rmid_rd_data", {16'd0, rd_data}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    read_who_am_i("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_spi_mnrch

// File: doc/spi_mnrch.md
Name: spi_mnrch

Overview:
- SPI monarch (master) issuing one 16-bit full-duplex transaction per `wrt` pulse.
- Drives `SS_n`, `SCLK` and `MOSI`, and captures `MISO`.
- Used to read and write registers of the inertial sensor (iNEMO): command byte in bits [15:8], data or don't-care in bits [7:0].
- Read data is returned on `rd_data`, with `done` flagging completion.

Parameters:
- None. `SCLK` = `clk`/16 and the transaction length of 16 bits are fixed.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- wrt  in  1  one-cycle start strobe; ignored unless idle
- wt_data  in  16  word to transmit, sent MSB first, captured on `wrt`
- rd_data  out  16  received word (shift register contents)
- done  out  1  set when the transaction completes; held until the next accepted `wrt`
- SS_n  out  1  active-low serf select
- SCLK  out  1  serial clock, idles high
- MOSI  out  1  serial data out = shift register bit 15
- MISO  in  1  serial data in

Behaviour:
- Reset state (asynchronous):
  - state=IDLE, `SS_n`=1, `SCLK`=1, `done`=0.
  - shift register=0, so `MOSI`=0 and `rd_data`=0.
  - bit counter=0, `SCLK` divider=4'b1011.
- `SCLK` generation: `SCLK` = `SCLK_div[3]`, where `SCLK_div` is a 4-bit counter.
  - Held at 4'b1011 in IDLE; increments every clk otherwise.
  - Falling edge occurs on the wrap 1111->0000; rising edge on 0111->1000.
- IDLE -> FRONT when `wrt`=1:
  - Load shift register with `wt_data`, clear bit counter, reload `SCLK_div`=1011.
  - `SS_n`<=0, `done`<=0.
  - `MOSI` presents `wt_data[15]` from the cycle after `wrt`.
- FRONT (front porch):
  - `SCLK` stays high for 5 clks.
  - When `SCLK_div`==1111 -> SHIFT, with no shift on this first fall.
- SHIFT:
  - smpl when `SCLK_div`==0111 (clk before `SCLK` rises): `MISO_smpl`<=`MISO`.
  - shft when `SCLK_div`==1111 (clk before `SCLK` falls): shift register <= {sr[14:0], `MISO_smpl`}; bit counter++.
  - When smpl occurs with bit counter==15 (the 16th sample) -> BACK.
- BACK (back porch):
  - Keeps counting until `SCLK_div`==1111. On that clk:
    - perform the 16th shift;
    - `done`<=1, `SS_n`<=1;
    - `SCLK_div`<=1011, so `SCLK` never falls again;
    - -> IDLE.
- Timing:
  - `done` rises ≈ 5 + 15·16 + 8 + 8 ≈ 261 clks after `SS_n` falls, and in all cases fewer than 300 clks after `wrt`.
  - `SS_n` rises on the same edge as `done`.
  - Exactly 16 `SCLK` falling and 16 rising edges per transaction.
- Data alignment: serf drives `MISO` on falling edges and samples `MOSI` on rising edges. Mode 3 (CPOL=1, CPHA=1).
- `rd_data` = shift register; valid when `done`=1. `rd_data[7:0]` holds the read byte for a read command.
- `wrt` while not IDLE: ignored.
- `wrt` in the same cycle `done` is set: ignored; a new `wrt` is accepted from the following cycle.
- Reset mid-transaction: immediate abort to the reset state, with `SS_n` and `SCLK` high.
- Outputs `SS_n` and `done` are flops, so they are glitch-free.

Decomposition:
- Shared package `spi_pkg`:
  - state enum {IDLE, FRONT, SHIFT, BACK};
  - constants SCLK_DIV_INIT=4'b1011, SMPL_PT=4'b0111, SHFT_PT=4'b1111, NUM_BITS=16.
- Single module; no sub-module needed. The datapath (divider, bit counter, shift register, `MISO` sample flop) and the FSM fit in one file.

Test Plan:
- Reset:
  - After `rst_n` rises: `SS_n`=1, `SCLK`=1, `done`=0.
  - `SCLK` constant while idle for 50 clks.
- WHO_AM_I read:
  - Against the iNEMO serf model: pulse `wrt` with `wt_data`=16'h8F00.
  - `SS_n`=0 on the next posedge; `done` within 300 clks; `rd_data[7:0]`=8'h6A.
  - `SS_n` returns to 1 within 8 clks of `done`, with `SCLK`=1.
- Register write:
  - `wrt` with 16'h0D02.
  - Serf register 0x0D becomes 8'h02; the serf setup flag sets within 300 clks and the serf asserts `INT`.
- Bit timing:
  - Send 16'hA55A with `MISO` looped to `MOSI`.
  - Exactly 16 falls and 16 rises are counted; the `MOSI` sequence at rising edges equals A55A.
  - `rd_data`=16'hA55A.
- `wrt` mid-transfer:
  - Pulse `wrt` with 16'hFFFF during SHIFT.
  - Ignored: the original word completes unchanged and `done` occurs once.
- Reset mid-transfer:
  - Assert `rst_n`=0 during SHIFT.
  - `SS_n`=1, `SCLK`=1 and `done`=0 immediately.
  - A subsequent 16'h8F00 read completes correctly.
